// File: rtl/line_scan_sequencer.sv
// -----------------------------------------------------------------------------
// line_scan_sequencer
//
// Sequences one full-frame pass of a 2-D sliding-window stage. Feeds
// k = 0 .. F-1 (F = ROWS + 2*HALO) are issued one per un-held RUN cycle. Each
// feed is either an SRAM row read or a zero push for the halo rows above and
// below the frame. Both kinds travel through the same RD_LAT-deep delay pipe,
// so line-buffer pushes always arrive in feed order. Once 2*HALO+1 feeds have
// been pushed, every further push completes the window centred on one output
// row, which is then announced on row_valid / wr_we.
//
// Ports
//   clk        clock
//   rst_n      synchronous, active-low reset
//   start      begin a pass (sampled only in IDLE)
//   hold       consumer back-pressure; suppresses new feed issue in RUN
//   rd_addr    source SRAM row address (valid in the issue cycle)
//   buffer_we  line buffer shift/write strobe
//   fill_zero  with buffer_we: push an all-zero row instead of SRAM data
//   row_valid  window centred on out_row is complete
//   out_row    output row index qualified by row_valid
//   wr_we      result SRAM write enable (same as row_valid)
//   wr_addr    result SRAM row address (same as out_row)
//   busy       pass in progress (RUN or DRAIN)
//   done       one-cycle pulse at pass completion
// -----------------------------------------------------------------------------
module line_scan_sequencer #(
   parameter int ROWS   = 480,
   parameter int AW     = 9,
   parameter int HALO   = 3,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          hold,
   output logic [AW-1:0] rd_addr,
   output logic          buffer_we,
   output logic          fill_zero,
   output logic          row_valid,
   output logic [AW-1:0] out_row,
   output logic          wr_we,
   output logic [AW-1:0] wr_addr,
   output logic          busy,
   output logic          done
);

   localparam int F  = ROWS + 2 * HALO;
   localparam int KW = $clog2(F);
   localparam int DW = $clog2(RD_LAT + 1) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state;
   logic [KW-1:0]     feed_k;     // next feed to issue
   logic [KW-1:0]     push_k;     // feed index of the next push to land
   logic [DW-1:0]     drain_cnt;
   logic [AW-1:0]     rd_addr_q;  // last issued address, held between issues
   logic [RD_LAT-1:0] pipe_v;     // delay pipe: push pending
   logic [RD_LAT-1:0] pipe_z;     // delay pipe: pending push is a zero row
   logic              row_valid_q;
   logic [AW-1:0]     out_row_q;

   logic              issue;
   logic              feed_zero;
   logic              last_feed;
   logic [KW-1:0]     feed_r;
   logic [AW-1:0]     feed_addr;
   logic              win_ready;

   // NOTE: every signal gets a default at the top of the block so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      issue     = 1'b0;
      feed_zero = 1'b0;
      last_feed = 1'b0;
      feed_r    = '0;
      feed_addr = '0;
      win_ready = 1'b0;

      issue     = (state == S_RUN) && !hold;
      feed_zero = (feed_k < KW'(HALO)) || (feed_k >= KW'(ROWS + HALO));
      last_feed = (feed_k == KW'(F - 1));
      feed_r    = feed_k - KW'(HALO);
      feed_addr = feed_zero ? '0 : AW'(feed_r);
      // A push of feed k >= 2*HALO completes the window of row k - 2*HALO.
      win_ready = buffer_we && (push_k >= KW'(2 * HALO));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values; reset here is synchronous.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         feed_k      <= '0;
         push_k      <= '0;
         drain_cnt   <= '0;
         rd_addr_q   <= '0;
         pipe_v      <= '0;
         pipe_z      <= '0;
         row_valid_q <= 1'b0;
         out_row_q   <= '0;
      end else begin
         // Reads and zero pushes share one pipe so push order equals feed order.
         pipe_v[0] <= issue;
         pipe_z[0] <= issue && feed_zero;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_z[i] <= pipe_z[i-1];
         end

         if (state == S_IDLE)
            push_k <= '0;
         else if (buffer_we)
            push_k <= push_k + 1'b1;

         row_valid_q <= win_ready;
         if (win_ready)
            out_row_q <= AW'(push_k - KW'(2 * HALO));

         case (state)
            S_IDLE: begin
               feed_k    <= '0;
               drain_cnt <= '0;
               rd_addr_q <= '0;
               if (start)
                  state <= S_RUN;
            end
            S_RUN: begin
               if (issue) begin
                  rd_addr_q <= feed_addr;
                  feed_k    <= feed_k + 1'b1;
                  if (last_feed)
                     state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // RD_LAT+1 cycles: lets the last push land and its row_valid register.
               if (drain_cnt == DW'(RD_LAT))
                  state <= S_DONE;
               else
                  drain_cnt <= drain_cnt + 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rd_addr   = '0;
      busy      = (state == S_RUN) || (state == S_DRAIN);
      done      = (state == S_DONE);
      buffer_we = pipe_v[RD_LAT-1];
      fill_zero = pipe_z[RD_LAT-1];
      row_valid = row_valid_q;
      wr_we     = row_valid_q;
      out_row   = out_row_q;
      wr_addr   = out_row_q;
      if (busy)
         rd_addr = issue ? feed_addr : rd_addr_q;
   end

endmodule

// File: tb/tb_line_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_line_scan_sequencer
//
// Three sequencer instances (default, ROWS=8/HALO=1, RD_LAT=2) share one
// stimulus stream of start / hold / reset. An event-schedule reference model
// predicts every output of every instance in every cycle. Directed segments
// are described by a table of {stimulus, expected pass metrics} records; a
// randomised segment follows.
// -----------------------------------------------------------------------------
module tb_line_scan_sequencer;

   localparam int NC = 4600;
   localparam int RB = 2000;  // first cycle of the randomised segment

   typedef struct packed {
      logic [8:0] rd_addr;
      logic       buffer_we;
      logic       fill_zero;
      logic       row_valid;
      logic [8:0] out_row;
      logic       wr_we;
      logic [8:0] wr_addr;
      logic       busy;
      logic       done;
   } out_t;

   typedef struct {
      int base;  int len;
      int hold_from; int hold_len;
      int spur0; int spur1;
      int rst_at; int restart;
      int e_done_cnt; int e_done_at; int e_rv; int e_we; int e_fz;
      int e_first_rv; int e_rv_hold;
   } seg_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic hold = 1'b0;

   always #5 clk = ~clk;

   logic [8:0] d0_rd_addr, d0_out_row, d0_wr_addr;
   logic       d0_buffer_we, d0_fill_zero, d0_row_valid, d0_wr_we, d0_busy, d0_done;
   logic [2:0] d1_rd_addr, d1_out_row, d1_wr_addr;
   logic       d1_buffer_we, d1_fill_zero, d1_row_valid, d1_wr_we, d1_busy, d1_done;
   logic [8:0] d2_rd_addr, d2_out_row, d2_wr_addr;
   logic       d2_buffer_we, d2_fill_zero, d2_row_valid, d2_wr_we, d2_busy, d2_done;

   line_scan_sequencer dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .rd_addr(d0_rd_addr), .buffer_we(d0_buffer_we), .fill_zero(d0_fill_zero),
      .row_valid(d0_row_valid), .out_row(d0_out_row), .wr_we(d0_wr_we),
      .wr_addr(d0_wr_addr), .busy(d0_busy), .done(d0_done));

   line_scan_sequencer #(.ROWS(8), .AW(3), .HALO(1), .RD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .rd_addr(d1_rd_addr), .buffer_we(d1_buffer_we), .fill_zero(d1_fill_zero),
      .row_valid(d1_row_valid), .out_row(d1_out_row), .wr_we(d1_wr_we),
      .wr_addr(d1_wr_addr), .busy(d1_busy), .done(d1_done));

   line_scan_sequencer #(.ROWS(480), .AW(9), .HALO(3), .RD_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .rd_addr(d2_rd_addr), .buffer_we(d2_buffer_we), .fill_zero(d2_fill_zero),
      .row_valid(d2_row_valid), .out_row(d2_out_row), .wr_we(d2_wr_we),
      .wr_addr(d2_wr_addr), .busy(d2_busy), .done(d2_done));

   out_t got0, got1, got2;
   assign got0 = {d0_rd_addr, d0_buffer_we, d0_fill_zero, d0_row_valid, d0_out_row,
                  d0_wr_we, d0_wr_addr, d0_busy, d0_done};
   assign got1 = {6'd0, d1_rd_addr, d1_buffer_we, d1_fill_zero, d1_row_valid,
                  6'd0, d1_out_row, d1_wr_we, 6'd0, d1_wr_addr, d1_busy, d1_done};
   assign got2 = {d2_rd_addr, d2_buffer_we, d2_fill_zero, d2_row_valid, d2_out_row,
                  d2_wr_we, d2_wr_addr, d2_busy, d2_done};

   bit   start_s [NC];
   bit   hold_s  [NC];
   bit   rst_s   [NC];
   out_t exp_tab [3][NC];

   bit ev_we [NC+8];
   bit ev_fz [NC+8];
   bit ev_rv [NC+8];
   int ev_row[NC+8];

   seg_t segs[3];
   int m_done_cnt[3], m_done_at[3], m_rv[3], m_we[3], m_fz[3], m_first_rv[3], m_rv_hold[3];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int where, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0d: got %h expected %h", name, where, got, exp);
      end
   endtask

   // Event-schedule model: each issued feed posts its push and (when it
   // completes a window) its row announcement at fixed future cycles.
   task automatic predict(input int d, input int rows, input int halo, input int lat);
      int   f, mode, n, done_c, last_rd, last_row;
      bit   zero;
      out_t e;
      f = rows + 2 * halo;
      mode = 0; n = 0; done_c = -1; last_rd = 0; last_row = 0;
      for (int i = 0; i < NC + 8; i++) begin
         ev_we[i] = 0; ev_fz[i] = 0; ev_rv[i] = 0; ev_row[i] = 0;
      end
      for (int c = 0; c < NC; c++) begin
         e = '0;
         e.buffer_we = ev_we[c];
         e.fill_zero = ev_fz[c];
         if (ev_rv[c]) last_row = ev_row[c];
         e.row_valid = ev_rv[c];
         e.wr_we     = ev_rv[c];
         e.out_row   = 9'(last_row);
         e.wr_addr   = 9'(last_row);
         if (mode == 0) begin            // idle
            if (start_s[c]) begin
               mode = 1; n = 0; last_rd = 0;
            end
         end else if (mode == 1) begin   // feeding
            e.busy = 1'b1;
            if (!hold_s[c]) begin
               zero    = (n < halo) || (n >= halo + rows);
               last_rd = zero ? 0 : n - halo;
               ev_we[c+lat] = 1'b1;
               ev_fz[c+lat] = zero;
               if (n >= 2 * halo) begin
                  ev_rv[c+lat+1]  = 1'b1;
                  ev_row[c+lat+1] = n - 2 * halo;
               end
               n++;
               if (n == f) begin
                  mode = 2; done_c = c + lat + 2;
               end
            end
            e.rd_addr = 9'(last_rd);
         end else begin                  // waiting for the tail, then done
            if (c == done_c) begin
               e.done = 1'b1; mode = 0;
            end else begin
               e.busy = 1'b1; e.rd_addr = 9'(last_rd);
            end
         end
         if (rst_s[c]) begin
            mode = 0; last_row = 0;
            for (int i = c + 1; i < NC + 8; i++) begin
               ev_we[i] = 0; ev_fz[i] = 0; ev_rv[i] = 0;
            end
         end
         exp_tab[d][c] = e;
      end
   endtask

   initial begin
      int seg, rel, b, next_row, push_idx;

      //            base  len  hold    spur       rst/restart  done  at   rv   we   fz first hold_rv
      segs[0] = '{0,    600,  0,  0, 100, 489,  -1,  -1,        1, 489, 480, 486, 6, 9, 0};
      segs[1] = '{600,  600, 50, 10,  -1,  -1,  -1,  -1,        1, 499, 480, 486, 6, 9, 2};
      segs[2] = '{1200, 800,  0,  0,  -1,  -1, 200, 205,        1, 694, 672, 685, 9, 9, 0};

      for (int c = 0; c < NC; c++) begin
         start_s[c] = 0; hold_s[c] = 0; rst_s[c] = 0;
      end
      for (int i = 0; i < 3; i++) begin
         b = segs[i].base;
         start_s[b] = 1;
         if (segs[i].spur0 >= 0)   start_s[b + segs[i].spur0]   = 1;
         if (segs[i].spur1 >= 0)   start_s[b + segs[i].spur1]   = 1;
         if (segs[i].rst_at >= 0)  rst_s[b + segs[i].rst_at]    = 1;
         if (segs[i].restart >= 0) start_s[b + segs[i].restart] = 1;
         for (int j = 0; j < segs[i].hold_len; j++) hold_s[b + segs[i].hold_from + j] = 1;
         m_done_cnt[i] = 0; m_done_at[i] = -1; m_rv[i] = 0; m_we[i] = 0;
         m_fz[i] = 0; m_first_rv[i] = -1; m_rv_hold[i] = 0;
      end
      start_s[RB] = 1;
      for (int c = RB + 1; c < NC; c++) begin
         start_s[c] = ($urandom_range(0, 149) == 0);
         hold_s[c]  = ($urandom_range(0, 3) == 0);
      end
      rst_s[RB + $urandom_range(700, 1500)] = 1;

      predict(0, 480, 3, 1);
      predict(1, 8, 1, 1);
      predict(2, 480, 3, 2);

      next_row = 0;
      push_idx = 0;
      repeat (3) @(posedge clk);
      for (int c = 0; c < NC; c++) begin
         @(posedge clk);
         #1;
         rst_n = !rst_s[c];
         start = start_s[c];
         hold  = hold_s[c];
         @(negedge clk);

         check("dut0_outputs", c, 64'(got0), 64'(exp_tab[0][c]));
         check("dut1_outputs", c, 64'(got1), 64'(exp_tab[1][c]));
         check("dut2_outputs", c, 64'(got2), 64'(exp_tab[2][c]));
         if (c == 0)
            check("reset_state", c, 64'(got0), 64'd0);
         if (c == segs[2].base + segs[2].rst_at + 1)
            check("post_reset_zero", c, 64'(got0), 64'd0);

         // Row numbers and zero-push positions follow directly from the frame geometry.
         if (got0.row_valid === 1'b1) begin
            check("row_order", c, 64'(got0.out_row), 64'(next_row));
            next_row = (next_row + 1) % 480;
         end
         if (got0.buffer_we === 1'b1) begin
            check("fill_zero_pos", c, 64'(got0.fill_zero), 64'(push_idx < 3 || push_idx >= 483));
            push_idx = (push_idx + 1) % 486;
         end
         if (rst_s[c]) begin
            next_row = 0; push_idx = 0;
         end

         seg = -1;
         for (int i = 0; i < 3; i++)
            if (c >= segs[i].base && c < segs[i].base + segs[i].len) seg = i;
         if (seg >= 0) begin
            rel = c - segs[seg].base;
            if (got0.done === 1'b1) begin
               m_done_cnt[seg]++; m_done_at[seg] = rel;
            end
            if (got0.row_valid === 1'b1) begin
               m_rv[seg]++;
               if (m_first_rv[seg] < 0) m_first_rv[seg] = rel;
               if (rel >= segs[seg].hold_from && rel < segs[seg].hold_from + segs[seg].hold_len)
                  m_rv_hold[seg]++;
            end
            if (got0.buffer_we === 1'b1) m_we[seg]++;
            if (got0.buffer_we === 1'b1 && got0.fill_zero === 1'b1) m_fz[seg]++;
         end
      end

      for (int i = 0; i < 3; i++) begin
         check("seg_done_count", i, 64'(m_done_cnt[i]), 64'(segs[i].e_done_cnt));
         check("seg_done_cycle", i, 64'(m_done_at[i]),  64'(segs[i].e_done_at));
         check("seg_row_valids", i, 64'(m_rv[i]),       64'(segs[i].e_rv));
         check("seg_pushes",     i, 64'(m_we[i]),       64'(segs[i].e_we));
         check("seg_zero_push",  i, 64'(m_fz[i]),       64'(segs[i].e_fz));
         check("seg_first_row",  i, 64'(m_first_rv[i]), 64'(segs[i].e_first_rv));
         check("seg_rv_in_hold", i, 64'(m_rv_hold[i]),  64'(segs[i].e_rv_hold));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
